usb_edge_filter: RTL and testbench

Parametrised multi-channel edge detector for the USB receive path, succeeding the single-channel D+ transition detector. Each channel synchronises its raw input through a configurable-depth flop chain, rejects glitches shorter than a programmable number of cycles, and emits a registered one-cycle edge pulse qualified by a selectable edge mode. Each channel also keeps a saturating edge counter for link diagnostics. It sits between the bus input pins (D+, D-) and the RX decoder/timer logic.

---
 rtl/usb_edge_filter_if.sv | 27 ++
 rtl/usb_edge_filter.sv | 103 ++++++++++
 tb/tb_usb_edge_filter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_edge_filter_if.sv
// Line-input bundle for the USB RX edge filter: raw pins in, filtered level/edges/counters out.
// No latency of its own; carries the filter's registered outputs.
// No backpressure: every signal is level-sampled each clock.
interface usb_edge_filter_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       d_in;
  logic [1:0]              mode;
  logic                    clr_cnt;
  logic [NUM_CH-1:0]       d_level;
  logic [NUM_CH-1:0]       d_edge;
  logic                    any_edge;
  logic [NUM_CH*CNT_W-1:0] edge_cnt;

  // Driver of the raw lines and controls (pins / testbench side).
  modport master (
    output d_in, mode, clr_cnt,
    input  d_level, d_edge, any_edge, edge_cnt
  );

  // The edge filter itself.
  modport slave (
    input  d_in, mode, clr_cnt,
    output d_level, d_edge, any_edge, edge_cnt
  );
endinterface

// File: rtl/usb_edge_filter.sv
// Multi-channel synchronise + glitch-filter + qualified edge detector with saturating edge counters.
// Latency: level/edge update on edge SYNC_STAGES+FILTER_LEN-1 counting the capturing edge as edge 1.
// No backpressure: free-running, one decision per channel per clock.
module usb_edge_filter #(
  parameter int   NUM_CH      = 2,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 1,
  parameter logic RESET_VAL   = 1'b1,
  parameter int   CNT_W       = 8
) (
  input logic              clk,
  input logic              n_rst,
  usb_edge_filter_if.slave bus
);

  localparam int               RUN_W    = $clog2(FILTER_LEN) + 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_CH-1:0]       level_v;
  logic [NUM_CH-1:0]       edge_v;
  logic [NUM_CH*CNT_W-1:0] cnt_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // samp is the value entering the final synchroniser stage; that final stage
    // is merged with the level/run registers so a sample is judged as it lands.
    logic             samp;
    logic [RUN_W-1:0] run_q, run_d;
    logic             level_q, level_d;
    logic             edge_q, edge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    if (SYNC_STAGES > 1) begin : g_pre
      logic [SYNC_STAGES-2:0] pre_q;

      // Leading synchroniser flops, shifting the raw pin towards the filter.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          pre_q <= {(SYNC_STAGES-1){RESET_VAL}};
        end else begin
          pre_q[0] <= bus.d_in[i];
          for (int j = 1; j < SYNC_STAGES-1; j++) begin
            pre_q[j] <= pre_q[j-1];
          end
        end
      end

      assign samp = pre_q[SYNC_STAGES-2];
    end else begin : g_nopre
      assign samp = bus.d_in[i];
    end

    // Glitch filter, edge qualification and counter next-state.
    always_comb begin
      run_d   = '0;
      level_d = level_q;
      edge_d  = 1'b0;
      cnt_d   = cnt_q;
      if (samp != level_q) begin
        if (run_q == RUN_LAST) begin
          level_d = ~level_q;
          // Falling toggle is gated by mode[1], rising by mode[0].
          edge_d  = level_q ? bus.mode[1] : bus.mode[0];
        end else begin
          run_d = run_q + RUN_ONE;
        end
      end
      // A clear wins over a coincident edge; the pulse itself is unaffected.
      if (bus.clr_cnt) begin
        cnt_d = '0;
      end else if (edge_d && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    // Per-channel state; a reset mid-run throws away the partial count.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        run_q   <= '0;
        level_q <= RESET_VAL;
        edge_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        run_q   <= run_d;
        level_q <= level_d;
        edge_q  <= edge_d;
        cnt_q   <= cnt_d;
      end
    end

    assign level_v[i]                = level_q;
    assign edge_v[i]                 = edge_q;
    assign cnt_v[i*CNT_W +: CNT_W]   = cnt_q;
  end

  assign bus.d_level  = level_v;
  assign bus.d_edge   = edge_v;
  assign bus.edge_cnt = cnt_v;
  assign bus.any_edge = |edge_v;

endmodule

// File: tb/tb_usb_edge_filter.sv
// Directed bench for usb_edge_filter: three instances cover defaults, a 3-sample filter,
// and a 4-sample filter with 2-bit counters. Inputs are driven just after the falling
// edge and outputs are sampled on the falling edge, away from the active rising edge.
module tb_usb_edge_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def, rst_gl, rst_sat;
  int vectors = 0;
  int miscompares = 0;

  usb_edge_filter_if #(.NUM_CH(2), .CNT_W(8)) if_def ();
  usb_edge_filter_if #(.NUM_CH(2), .CNT_W(8)) if_gl ();
  usb_edge_filter_if #(.NUM_CH(2), .CNT_W(2)) if_sat ();

  usb_edge_filter #(.NUM_CH(2), .SYNC_STAGES(2), .FILTER_LEN(1), .RESET_VAL(1'b1), .CNT_W(8)) u_def (
    .clk(clk), .n_rst(rst_def), .bus(if_def)
  );
  usb_edge_filter #(.NUM_CH(2), .SYNC_STAGES(2), .FILTER_LEN(3), .RESET_VAL(1'b1), .CNT_W(8)) u_gl (
    .clk(clk), .n_rst(rst_gl), .bus(if_gl)
  );
  usb_edge_filter #(.NUM_CH(2), .SYNC_STAGES(2), .FILTER_LEN(4), .RESET_VAL(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .n_rst(rst_sat), .bus(if_sat)
  );

  task automatic test_reset();
    rst_def = 1'b0; rst_gl = 1'b0; rst_sat = 1'b0;
    if_def.d_in = 2'b00; if_def.mode = 2'b11; if_def.clr_cnt = 1'b0;
    if_gl.d_in  = 2'b11; if_gl.mode  = 2'b11; if_gl.clr_cnt  = 1'b0;
    if_sat.d_in = 2'b11; if_sat.mode = 2'b11; if_sat.clr_cnt = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (if_def.d_level !== 2'b11) begin
      $display("FAIL reset_hold_level: got %b want 11", if_def.d_level); miscompares++;
    end
    rst_def = 1'b1; rst_gl = 1'b1; rst_sat = 1'b1;
    #1;
    vectors++;
    if (if_def.d_level !== 2'b11) begin
      $display("FAIL reset_level: got %b want 11", if_def.d_level); miscompares++;
    end
    vectors++;
    if (if_def.d_edge !== 2'b00) begin
      $display("FAIL reset_edge: got %b want 00", if_def.d_edge); miscompares++;
    end
    vectors++;
    if (if_def.edge_cnt !== 16'h0000) begin
      $display("FAIL reset_cnt: got %h want 0000", if_def.edge_cnt); miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (if_def.d_edge !== 2'b00) begin
      $display("FAIL reset_edge_cyc1: got %b want 00", if_def.d_edge); miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (if_def.d_edge !== 2'b11) begin
      $display("FAIL reset_fall_pulse: got %b want 11", if_def.d_edge); miscompares++;
    end
    vectors++;
    if (if_def.d_level !== 2'b00) begin
      $display("FAIL reset_fall_level: got %b want 00", if_def.d_level); miscompares++;
    end
    vectors++;
    if (if_def.edge_cnt !== 16'h0101) begin
      $display("FAIL reset_fall_cnt: got %h want 0101", if_def.edge_cnt); miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (if_def.d_edge !== 2'b00) begin
      $display("FAIL reset_pulse_width: got %b want 00", if_def.d_edge); miscompares++;
    end
  endtask

  task automatic test_latency_mode();
    logic seen;
    int   pulses;
    // mode 00: level follows, nothing pulses or counts.
    if_def.mode = 2'b00; if_def.d_in = 2'b11;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | (|if_def.d_edge);
    end
    vectors++;
    if (seen !== 1'b0) begin
      $display("FAIL mode00_pulse: got %b want 0", seen); miscompares++;
    end
    vectors++;
    if (if_def.d_level !== 2'b11) begin
      $display("FAIL mode00_level: got %b want 11", if_def.d_level); miscompares++;
    end
    vectors++;
    if (if_def.edge_cnt !== 16'h0101) begin
      $display("FAIL mode00_cnt: got %h want 0101", if_def.edge_cnt); miscompares++;
    end
    if_def.clr_cnt = 1'b1; if_def.mode = 2'b01;
    @(negedge clk);
    if_def.clr_cnt = 1'b0;
    vectors++;
    if (if_def.edge_cnt !== 16'h0000) begin
      $display("FAIL clr_cnt: got %h want 0000", if_def.edge_cnt); miscompares++;
    end
    // Falling on ch0 with rising-only mode.
    if_def.d_in = 2'b10;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (if_def.d_edge[0]) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      $display("FAIL rise_only_fall_pulses: got %0d want 0", pulses); miscompares++;
    end
    vectors++;
    if (if_def.d_level !== 2'b10) begin
      $display("FAIL rise_only_fall_level: got %b want 10", if_def.d_level); miscompares++;
    end
    // Rising on ch0: pulse on the second edge counting the capture edge.
    if_def.d_in = 2'b11;
    @(negedge clk);
    vectors++;
    if (if_def.d_edge !== 2'b00) begin
      $display("FAIL rise_capture_edge: got %b want 00", if_def.d_edge); miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (if_def.d_edge !== 2'b01) begin
      $display("FAIL rise_pulse: got %b want 01", if_def.d_edge); miscompares++;
    end
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_def.d_edge[0]) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      $display("FAIL rise_extra_pulses: got %0d want 0", pulses); miscompares++;
    end
    vectors++;
    if (if_def.edge_cnt !== 16'h0001) begin
      $display("FAIL rise_cnt: got %h want 0001", if_def.edge_cnt); miscompares++;
    end
  endtask

  task automatic test_glitch();
    // ch0 stimulus per cycle: 1-cycle low, 2-cycle low, 3-cycle low glitches.
    logic [0:20] in_seq  = 21'b101110011110001111111;
    logic [0:20] lvl_seq = 21'b111111111111111000111;
    logic [0:20] edg_seq = 21'b000000000000000100100;
    for (int k = 0; k < 21; k++) begin
      vectors++;
      if (if_gl.d_level[0] !== lvl_seq[k]) begin
        $display("FAIL glitch_level[%0d]: got %b want %b", k, if_gl.d_level[0], lvl_seq[k]); miscompares++;
      end
      vectors++;
      if (if_gl.d_edge[0] !== edg_seq[k]) begin
        $display("FAIL glitch_edge[%0d]: got %b want %b", k, if_gl.d_edge[0], edg_seq[k]); miscompares++;
      end
      if_gl.d_in = {1'b1, in_seq[k]};
      @(negedge clk);
    end
    vectors++;
    if (if_gl.edge_cnt !== 16'h0002) begin
      $display("FAIL glitch_cnt: got %h want 0002", if_gl.edge_cnt); miscompares++;
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      if_sat.d_in[1] = ~if_sat.d_in[1];
      repeat (5) @(negedge clk);
      vectors++;
      if (if_sat.d_edge !== 2'b10) begin
        $display("FAIL sat_edge[%0d]: got %b want 10", i, if_sat.d_edge); miscompares++;
      end
      vectors++;
      if (if_sat.edge_cnt !== {exp_cnt[i], 2'b00}) begin
        $display("FAIL sat_cnt[%0d]: got %b want %b", i, if_sat.edge_cnt, {exp_cnt[i], 2'b00}); miscompares++;
      end
      repeat (3) @(negedge clk);
    end
    // Sixth edge coincides with a clear.
    if_sat.d_in[1] = ~if_sat.d_in[1];
    repeat (4) @(negedge clk);
    vectors++;
    if (if_sat.edge_cnt !== 4'b1100) begin
      $display("FAIL sat_pre_clr_cnt: got %b want 1100", if_sat.edge_cnt); miscompares++;
    end
    if_sat.clr_cnt = 1'b1;
    @(negedge clk);
    if_sat.clr_cnt = 1'b0;
    vectors++;
    if (if_sat.d_edge !== 2'b10) begin
      $display("FAIL clr_edge_pulse: got %b want 10", if_sat.d_edge); miscompares++;
    end
    vectors++;
    if (if_sat.edge_cnt !== 4'b0000) begin
      $display("FAIL clr_edge_cnt: got %b want 0000", if_sat.edge_cnt); miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (if_sat.edge_cnt !== 4'b0000) begin
      $display("FAIL clr_after_cnt: got %b want 0000", if_sat.edge_cnt); miscompares++;
    end
  endtask

  task automatic test_independence();
    if_def.mode = 2'b11; if_def.d_in = 2'b00;
    @(negedge clk);
    vectors++;
    if (if_def.any_edge !== 1'b0) begin
      $display("FAIL indep_early_any: got %b want 0", if_def.any_edge); miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (if_def.d_edge !== 2'b11) begin
      $display("FAIL indep_edge: got %b want 11", if_def.d_edge); miscompares++;
    end
    vectors++;
    if (if_def.any_edge !== 1'b1) begin
      $display("FAIL indep_any: got %b want 1", if_def.any_edge); miscompares++;
    end
    vectors++;
    if (if_def.edge_cnt !== 16'h0102) begin
      $display("FAIL indep_cnt: got %h want 0102", if_def.edge_cnt); miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (if_def.any_edge !== 1'b0) begin
      $display("FAIL indep_any_width: got %b want 0", if_def.any_edge); miscompares++;
    end
  endtask

  task automatic test_mid_reset();
    logic seen;
    logic moved;
    if_sat.d_in = 2'b10;
    repeat (3) @(negedge clk);
    vectors++;
    if (if_sat.d_level !== 2'b11) begin
      $display("FAIL midrst_pre_level: got %b want 11", if_sat.d_level); miscompares++;
    end
    rst_sat = 1'b0;
    if_sat.d_in = 2'b11;
    #1;
    vectors++;
    if (if_sat.d_level !== 2'b11) begin
      $display("FAIL midrst_level: got %b want 11", if_sat.d_level); miscompares++;
    end
    vectors++;
    if (if_sat.d_edge !== 2'b00) begin
      $display("FAIL midrst_edge: got %b want 00", if_sat.d_edge); miscompares++;
    end
    repeat (2) @(negedge clk);
    rst_sat = 1'b1;
    seen = 1'b0; moved = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen  = seen | (|if_sat.d_edge);
      moved = moved | (if_sat.d_level != 2'b11);
    end
    vectors++;
    if (seen !== 1'b0) begin
      $display("FAIL midrst_post_pulse: got %b want 0", seen); miscompares++;
    end
    vectors++;
    if (moved !== 1'b0) begin
      $display("FAIL midrst_post_level: got %b want 0", moved); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_latency_mode();
    test_glitch();
    test_saturation();
    test_independence();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
